// File: rtl/acc_alu_reg.sv
// rtl/acc_alu_reg.sv - registered accumulator ALU (LOAD/ADD/SUB/CLEAR) with result flags and sticky overflow
// Optional build macro ACC_SATURATE_EN: clamp ADD/SUB results on signed overflow instead of wrapping.
module acc_alu_reg #(
    parameter int NBITS = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [1:0]       i_op,
    input  logic [NBITS-1:0] i_operand,
    input  logic             i_clr_flags,
    output logic [NBITS-1:0] o_acc,
    output logic             o_done,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_ovf_sticky
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [NBITS-1:0] r_acc;
    logic             r_done;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic             r_ovf_sticky;

    logic             w_sub;
    logic [NBITS-1:0] w_b;
    logic [NBITS:0]   w_sum;
    logic             w_ovf_arith;
    logic [NBITS-1:0] w_arith_acc;
    logic [NBITS-1:0] w_next_acc;
    logic             w_next_carry;
    logic             w_next_ovf;

    // SUB reuses the adder as acc + ~operand + 1, so one overflow rule covers both
    always_comb begin
        w_sub       = (i_op == OP_SUB);
        w_b         = w_sub ? ~i_operand : i_operand;
        w_sum       = {1'b0, r_acc} + {1'b0, w_b} + {{NBITS{1'b0}}, w_sub};
        w_ovf_arith = (r_acc[NBITS-1] == w_b[NBITS-1]) && (w_sum[NBITS-1] != r_acc[NBITS-1]);
`ifdef ACC_SATURATE_EN
        if (w_ovf_arith)
            w_arith_acc = r_acc[NBITS-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
        else
            w_arith_acc = w_sum[NBITS-1:0];
`else
        w_arith_acc = w_sum[NBITS-1:0];
`endif
    end

    always_comb begin
        w_next_acc   = '0;
        w_next_carry = 1'b0;
        w_next_ovf   = 1'b0;
        case (i_op)
            OP_LOAD:  w_next_acc = i_operand;
            OP_ADD, OP_SUB: begin
                w_next_acc   = w_arith_acc;
                w_next_carry = w_sum[NBITS];
                w_next_ovf   = w_ovf_arith;
            end
            OP_CLEAR: w_next_acc = '0;
            default:  w_next_acc = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_acc        <= '0;
            r_done       <= 1'b0;
            r_zero       <= 1'b1;
            r_neg        <= 1'b0;
            r_carry      <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_done <= i_valid;
            if (i_valid) begin
                r_acc   <= w_next_acc;
                r_zero  <= (w_next_acc == '0);
                r_neg   <= w_next_acc[NBITS-1];
                r_carry <= w_next_carry;
                r_ovf   <= w_next_ovf;
            end
            // a new overflow wins over a same-cycle clear request
            if (i_valid && w_next_ovf)
                r_ovf_sticky <= 1'b1;
            else if (i_clr_flags)
                r_ovf_sticky <= 1'b0;
        end
    end

    assign o_acc        = r_acc;
    assign o_done       = r_done;
    assign o_zero       = r_zero;
    assign o_neg        = r_neg;
    assign o_carry      = r_carry;
    assign o_ovf        = r_ovf;
    assign o_ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_acc_alu_reg.sv
// tb/tb_acc_alu_reg.sv - table-driven bench for acc_alu_reg at NBITS = 16
module tb_acc_alu_reg;

    localparam int NBITS = 16;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic        rstn;
        logic        valid;
        logic [1:0]  op;
        logic [15:0] operand;
        logic        clr;
        logic [15:0] acc;
        logic        done;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
        logic        sticky;
        string       name;
    } vec_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             valid = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [NBITS-1:0] operand = '0;
    logic             clr = 1'b0;
    logic [NBITS-1:0] acc;
    logic             done, zero, neg, carry, ovf, sticky;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    acc_alu_reg #(.NBITS(NBITS)) dut (
        .i_clock     (clk),
        .i_reset     (rstn),
        .i_valid     (valid),
        .i_op        (op),
        .i_operand   (operand),
        .i_clr_flags (clr),
        .o_acc       (acc),
        .o_done      (done),
        .o_zero      (zero),
        .o_neg       (neg),
        .o_carry     (carry),
        .o_ovf       (ovf),
        .o_ovf_sticky(sticky)
    );

    task automatic add(input string nm, input logic r, input logic v, input logic [1:0] o,
                       input logic [15:0] b, input logic c, input logic [15:0] ea,
                       input logic ed, input logic ez, input logic en, input logic ec,
                       input logic eo, input logic es);
        vec_t t;
        t.name = nm; t.rstn = r; t.valid = v; t.op = o; t.operand = b; t.clr = c;
        t.acc = ea; t.done = ed; t.zero = ez; t.neg = en; t.carry = ec; t.ovf = eo; t.sticky = es;
        vecs.push_back(t);
    endtask

    task automatic apply(input vec_t t);
        logic [21:0] got, exp;
        @(negedge clk);
        rstn = t.rstn; valid = t.valid; op = t.op; operand = t.operand; clr = t.clr;
        @(posedge clk);
        #1;
        got = {acc, done, zero, neg, carry, ovf, sticky};
        exp = {t.acc, t.done, t.zero, t.neg, t.carry, t.ovf, t.sticky};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got acc=%h d=%b z=%b n=%b c=%b o=%b s=%b, expected acc=%h d=%b z=%b n=%b c=%b o=%b s=%b",
                     t.name, acc, done, zero, neg, carry, ovf, sticky,
                     t.acc, t.done, t.zero, t.neg, t.carry, t.ovf, t.sticky);
        end
    endtask

    initial begin
        //    name            rstn v  op     operand  clr acc      d  z  n  c  o  s
        add("reset0",         0, 1, 2'b01, 16'h1234, 0, 16'h0000, 0, 1, 0, 0, 0, 0);
        add("reset1",         0, 1, 2'b01, 16'h1234, 0, 16'h0000, 0, 1, 0, 0, 0, 0);
        add("load_7fff",      1, 1, 2'b00, 16'h7FFF, 0, 16'h7FFF, 1, 0, 0, 0, 0, 0);
        add("add_pos_ovf",    1, 1, 2'b01, 16'h0001, 0, SAT ? 16'h7FFF : 16'h8000, 1, 0, !SAT, 0, 1, 1);
        add("load_3",         1, 1, 2'b00, 16'h0003, 0, 16'h0003, 1, 0, 0, 0, 0, 1);
        add("sub_borrow",     1, 1, 2'b10, 16'h0005, 0, 16'hFFFE, 1, 0, 1, 0, 0, 1);
        add("sub_to_zero",    1, 1, 2'b10, 16'hFFFE, 0, 16'h0000, 1, 1, 0, 1, 0, 1);
        add("clr_idle",       1, 0, 2'b01, 16'h5555, 1, 16'h0000, 0, 1, 0, 1, 0, 0);
        add("b2b_load_1",     1, 1, 2'b00, 16'h0001, 0, 16'h0001, 1, 0, 0, 0, 0, 0);
        add("b2b_add_ffff",   1, 1, 2'b01, 16'hFFFF, 0, 16'h0000, 1, 1, 0, 1, 0, 0);
        add("prep_load",      1, 1, 2'b00, 16'h7FFF, 0, 16'h7FFF, 1, 0, 0, 0, 0, 0);
        add("prep_ovf",       1, 1, 2'b01, 16'h0001, 0, SAT ? 16'h7FFF : 16'h8000, 1, 0, !SAT, 0, 1, 1);
        add("load_keep_stk",  1, 1, 2'b00, 16'h7FFF, 0, 16'h7FFF, 1, 0, 0, 0, 0, 1);
        add("set_over_clr",   1, 1, 2'b01, 16'h7FFF, 1, SAT ? 16'h7FFF : 16'hFFFE, 1, 0, !SAT, 0, 1, 1);
        add("clr_alone",      1, 0, 2'b00, 16'h0000, 1, SAT ? 16'h7FFF : 16'hFFFE, 0, 0, !SAT, 0, 1, 0);
        add("load_43",        1, 1, 2'b00, 16'h0043, 0, 16'h0043, 1, 0, 0, 0, 0, 0);
        add("add_to_42",      1, 1, 2'b01, 16'hFFFF, 0, 16'h0042, 1, 0, 0, 1, 0, 0);
        add("idle0",          1, 0, 2'b11, 16'h0000, 0, 16'h0042, 0, 0, 0, 1, 0, 0);
        add("idle1",          1, 0, 2'b00, 16'hFFFF, 0, 16'h0042, 0, 0, 0, 1, 0, 0);
        add("idle2",          1, 0, 2'b10, 16'h0042, 0, 16'h0042, 0, 0, 0, 1, 0, 0);
        add("idle3",          1, 0, 2'b01, 16'h7FFF, 0, 16'h0042, 0, 0, 0, 1, 0, 0);
        add("idle4",          1, 0, 2'b11, 16'h8000, 0, 16'h0042, 0, 0, 0, 1, 0, 0);
        add("clear",          1, 1, 2'b11, 16'hABCD, 0, 16'h0000, 1, 1, 0, 0, 0, 0);
        add("load_8000",      1, 1, 2'b00, 16'h8000, 0, 16'h8000, 1, 0, 1, 0, 0, 0);
        add("sub_neg_ovf",    1, 1, 2'b10, 16'h0001, 0, SAT ? 16'h8000 : 16'h7FFF, 1, 0, SAT, 1, 1, 1);
        add("load_before_rst",1, 1, 2'b00, 16'h00FF, 0, 16'h00FF, 1, 0, 0, 0, 0, 1);
        add("reset_drops_op", 0, 1, 2'b00, 16'h1234, 1, 16'h0000, 0, 1, 0, 0, 0, 0);
        add("after_reset",    1, 1, 2'b01, 16'h8001, 0, 16'h8001, 1, 0, 1, 0, 0, 0);
        add("done_falls",     1, 0, 2'b01, 16'h0001, 0, 16'h8001, 0, 0, 1, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
